// File: rtl/fibo_pkg.sv
// Shared types and constants for the fibo_seq_engine slice.
//   state_e : engine control states (CONV is only reached with FIBO_BCD_OUT_EN)
//   mode_e  : recurrence selection, Fibonacci or Lucas
//   SEED*   : first two terms of each recurrence
package fibo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic {
        FIB = 1'b0,
        LUC = 1'b1
    } mode_e;

    localparam int unsigned SEED0_FIB = 0;
    localparam int unsigned SEED1_FIB = 1;
    localparam int unsigned SEED0_LUC = 2;
    localparam int unsigned SEED1_LUC = 1;

endpackage : fibo_pkg

// File: rtl/fibo_seq_engine_if.sv
// Start/done control interface of fibo_seq_engine.
//   begin_fibo : start pulse                (master -> slave)
//   input_s    : index n                    (master -> slave)
//   mode       : 0 Fibonacci, 1 Lucas       (master -> slave)
//   fibo_out   : term n, saturated          (slave -> master)
//   overflow   : term n exceeded range      (slave -> master)
//   busy       : run in progress            (slave -> master)
//   done       : result valid, held         (slave -> master)
//   fibo_bcd   : BCD of fibo_out, only when FIBO_BCD_OUT_EN is defined
interface fibo_seq_engine_if #(
    parameter int unsigned WIDTH      = 28,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned BCD_DIGITS = 9
) ();

    logic                    begin_fibo;
    logic [IDX_W-1:0]        input_s;
    logic                    mode;
    logic [WIDTH-1:0]        fibo_out;
    logic                    overflow;
    logic                    busy;
    logic                    done;
`ifdef FIBO_BCD_OUT_EN
    logic [4*BCD_DIGITS-1:0] fibo_bcd;
`endif

    modport master (
        output begin_fibo,
        output input_s,
        output mode,
        input  fibo_out,
        input  overflow,
        input  busy,
`ifdef FIBO_BCD_OUT_EN
        input  fibo_bcd,
`endif
        input  done
    );

    modport slave (
        input  begin_fibo,
        input  input_s,
        input  mode,
        output fibo_out,
        output overflow,
        output busy,
`ifdef FIBO_BCD_OUT_EN
        output fibo_bcd,
`endif
        output done
    );

endinterface : fibo_seq_engine_if

// File: rtl/fibo_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per clock.
//   clk, reset : clock and async active-low reset
//   start      : load bin and begin a WIDTH-cycle conversion
//   bin        : binary value to convert
//   busy       : conversion in progress
//   valid_c    : high during the final step; bcd updates on that edge
//   bcd        : last completed result, held until the next one
module fibo_bin2bcd #(
    parameter int unsigned WIDTH      = 28,
    parameter int unsigned BCD_DIGITS = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic                    valid_c,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned BCD_W = 4 * BCD_DIGITS;

    logic [WIDTH-1:0] sh;
    logic [BCD_W-1:0] acc;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt;

    // Add 3 to every digit >= 5 so the following shift carries correctly.
    always_comb begin
        adj = acc;
        for (int i = 0; i < int'(BCD_DIGITS); i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign acc_next = {adj[BCD_W-2:0], sh[WIDTH-1]};
    assign valid_c  = busy && (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh   <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            bcd  <= '0;
        end else if (start) begin
            sh   <= bin;
            acc  <= '0;
            cnt  <= CNT_W'(WIDTH);
            busy <= 1'b1;
        end else if (busy) begin
            sh  <= {sh[WIDTH-2:0], 1'b0};
            acc <= acc_next;
            cnt <= cnt - CNT_W'(1);
            if (valid_c) begin
                busy <= 1'b0;
                bcd  <= acc_next;
            end
        end
    end

endmodule : fibo_bin2bcd

// File: rtl/fibo_seq_engine.sv
// Two-seed additive recurrence engine: term n of Fibonacci or Lucas,
// one iteration per clock, with sticky saturating overflow.
//   clk, reset : clock and async active-low reset (0 = reset)
//   bus        : fibo_seq_engine_if.slave (begin_fibo, input_s, mode in;
//                fibo_out, overflow, busy, done, [fibo_bcd] out)
// Optional: FIBO_BCD_OUT_EN adds a WIDTH-cycle BCD conversion (CONV state)
// before done and drives bus.fibo_bcd.
module fibo_seq_engine
    import fibo_pkg::*;
#(
    parameter int unsigned WIDTH      = 28,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned BCD_DIGITS = 9
) (
    input  logic              clk,
    input  logic              reset,
    fibo_seq_engine_if.slave  bus
);

    state_e           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flag_a;
    logic             flag_b;
    logic [IDX_W-1:0] cnt;

    logic [WIDTH-1:0] fibo_out_q;
    logic             overflow_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   sum_c;
    logic             ovf_c;
    logic [WIDTH-1:0] sat_c;

    // Next term; once any contributor overflowed the value pins to all-ones.
    assign sum_c = {1'b0, a} + {1'b0, b};
    assign ovf_c = sum_c[WIDTH] | flag_a | flag_b;
    assign sat_c = ovf_c ? '1 : sum_c[WIDTH-1:0];

    assign bus.fibo_out = fibo_out_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

`ifdef FIBO_BCD_OUT_EN
    logic                    conv_start_c;
    logic                    conv_busy;
    logic                    conv_valid_c;
    logic [4*BCD_DIGITS-1:0] conv_bcd;

    // Conversion starts on the same edge that loads fibo_out, from the same a.
    assign conv_start_c = (state == CALC) && (cnt == '0);
    assign bus.fibo_bcd = conv_bcd;

    fibo_bin2bcd #(
        .WIDTH      (WIDTH),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .start   (conv_start_c),
        .bin     (a),
        .busy    (conv_busy),
        .valid_c (conv_valid_c),
        .bcd     (conv_bcd)
    );
`endif

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            a          <= '0;
            b          <= '0;
            flag_a     <= 1'b0;
            flag_b     <= 1'b0;
            cnt        <= '0;
            fibo_out_q <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.begin_fibo) begin
                        if (mode_e'(bus.mode) == LUC) begin
                            a <= WIDTH'(SEED0_LUC);
                            b <= WIDTH'(SEED1_LUC);
                        end else begin
                            a <= WIDTH'(SEED0_FIB);
                            b <= WIDTH'(SEED1_FIB);
                        end
                        cnt    <= bus.input_s;
                        flag_a <= 1'b0;
                        flag_b <= 1'b0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        a      <= b;
                        flag_a <= flag_b;
                        b      <= sat_c;
                        flag_b <= ovf_c;
                        cnt    <= cnt - IDX_W'(1);
                    end else begin
                        // Only term n (held in a) decides overflow; b may be past range.
                        fibo_out_q <= a;
                        overflow_q <= flag_a;
`ifdef FIBO_BCD_OUT_EN
                        state      <= CONV;
`else
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state      <= DONE;
`endif
                    end
                end
`ifdef FIBO_BCD_OUT_EN
                CONV: begin
                    if (conv_busy && conv_valid_c) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : fibo_seq_engine
